// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit path.
// Flag, abort pattern and frame-size limit live here so every block agrees on them.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    END_FLAG,
    ABORT
  } tx_state_e;

  localparam logic [7:0]  FLAG      = 8'h7E;
  localparam logic [7:0]  ABORT_PAT = 8'hFE;
  localparam int unsigned MAX_FRAME = 128;
  localparam int unsigned STUFF_RUN = 5;

  // A start request is honoured only for payload sizes 1..MAX_FRAME.
  function automatic logic size_ok(input logic [7:0] size);
    return (size != 8'd0) && (size <= 8'(MAX_FRAME));
  endfunction

endpackage

// File: rtl/hdlc_tx_bitstuffer.sv
// Zero-insertion tracker: counts consecutive payload ones already placed on the line.
// stall_o tells the sequencer that the next line bit must be an inserted 0.
module hdlc_tx_bitstuffer
  import hdlc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_i,
  input  logic bit_i,
  output logic stall_o
);

  logic [2:0] ones_q, ones_d;

  assign stall_o = (ones_q == 3'(STUFF_RUN));

  // Any cycle that is not loading a payload bit (flags, abort, idle) clears the run,
  // as does the inserted 0 itself.
  always_comb begin
    ones_d = '0;
    if (shift_i && !stall_o && bit_i) begin
      ones_d = ones_q + 3'd1;
    end
  end

  // NOTE: registers are updated with non-blocking assignments only, so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit sequencer: start flag, LSB-first payload with zero insertion, end flag,
// and an abort pattern on request. The state registers describe the bit currently on Tx.
module hdlc_tx_ctrl
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic [7:0] Tx_FrameSize,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] size_q, size_d;
  logic [7:0] data_q, data_d;
  logic       stuff_q, stuff_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  logic       shift, shift_bit, stall, last_byte;
  logic [2:0] next_bit;

  assign next_bit  = bit_q + 3'd1;
  assign last_byte = (byte_q == size_q - 8'd1);

  hdlc_tx_bitstuffer u_stuffer (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .shift_i (shift),
    .bit_i   (shift_bit),
    .stall_o (stall)
  );

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    size_d    = size_q;
    data_d    = data_q;
    stuff_d   = 1'b0;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    shift     = 1'b0;
    shift_bit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Tx_Enable && size_ok(Tx_FrameSize)) begin
          state_d = START_FLAG;
          bit_d   = 3'd0;
          byte_d  = 8'd0;
          size_d  = Tx_FrameSize;
          tx_d    = FLAG[0];
        end
      end
      START_FLAG: begin
        if (Tx_AbortFrame) begin
          state_d = ABORT;
          bit_d   = 3'd0;
          tx_d    = ABORT_PAT[0];
        end else if (bit_q == 3'd7) begin
          state_d   = DATA;
          bit_d     = 3'd0;
          data_d    = Tx_Data;
          tx_d      = Tx_Data[0];
          shift     = 1'b1;
          shift_bit = Tx_Data[0];
        end else begin
          bit_d = next_bit;
          tx_d  = FLAG[next_bit];
        end
      end
      DATA: begin
        if (Tx_AbortFrame) begin
          state_d = ABORT;
          bit_d   = 3'd0;
          tx_d    = ABORT_PAT[0];
        end else if (stall) begin
          // Inserted 0: bit index is held so the next payload bit resumes in place.
          stuff_d = 1'b1;
          tx_d    = 1'b0;
          shift   = 1'b1;
        end else if (bit_q == 3'd7) begin
          if (last_byte) begin
            state_d = END_FLAG;
            bit_d   = 3'd0;
            tx_d    = FLAG[0];
          end else begin
            byte_d    = byte_q + 8'd1;
            bit_d     = 3'd0;
            data_d    = Tx_Data;
            tx_d      = Tx_Data[0];
            shift     = 1'b1;
            shift_bit = Tx_Data[0];
          end
        end else begin
          bit_d     = next_bit;
          tx_d      = data_q[next_bit];
          shift     = 1'b1;
          shift_bit = data_q[next_bit];
        end
      end
      END_FLAG: begin
        if (bit_q == 3'd7) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          bit_d = next_bit;
          tx_d  = FLAG[next_bit];
        end
      end
      ABORT: begin
        if (bit_q == 3'd7) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          bit_d = next_bit;
          tx_d  = ABORT_PAT[next_bit];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      bit_q     <= 3'd0;
      byte_q    <= 8'd0;
      size_q    <= 8'd0;
      data_q    <= 8'd0;
      stuff_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      size_q    <= size_d;
      data_q    <= data_d;
      stuff_q   <= stuff_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // First byte is fetched at the first flag bit; each later byte while the real
  // (not inserted) bit 6 of the current byte is on the line.
  assign Tx_RdBuff = ((state_q == START_FLAG) && (bit_q == 3'd0)) ||
                     ((state_q == DATA) && (bit_q == 3'd6) && !stuff_q && !last_byte);

  assign Tx              = tx_q;
  assign Tx_Busy         = (state_q != IDLE);
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// Directed bench for hdlc_tx_ctrl: hand-computed line bit strings and strobe counts
// for normal frames, zero insertion, abort, illegal sizes and reset mid-frame.
module tb_hdlc_tx_ctrl;

  logic       Clk;
  logic       Rst;
  logic       Tx_Enable;
  logic [7:0] Tx_FrameSize;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  hdlc_tx_ctrl dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_Enable       (Tx_Enable),
    .Tx_FrameSize    (Tx_FrameSize),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx_Data         (Tx_Data),
    .Tx_RdBuff       (Tx_RdBuff),
    .Tx              (Tx),
    .Tx_Busy         (Tx_Busy),
    .Tx_Done         (Tx_Done),
    .Tx_AbortedTrans (Tx_AbortedTrans)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Tx buffer model
  logic [7:0] payload[$];
  int         rd_idx;
  bit         rd_pending;

  // Per-frame capture
  bit   tx_log[$];
  int   rd_cnt, done_cnt, ab_cnt, done_at, ab_at;
  logic idle_tx;
  bit   timed_out;

  function automatic string log_str();
    string s = "";
    foreach (tx_log[i]) s = {s, (tx_log[i] ? "1" : "0")};
    return s;
  endfunction

  function automatic int count_flags(input string s, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (s.substr(i, i + 7) == "01111110") n++;
    end
    return n;
  endfunction

  task automatic load_payload(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] src[4];
    src[0] = b0; src[1] = b1; src[2] = b2; src[3] = b3;
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(src[i]);
    rd_idx     = 0;
    rd_pending = 1'b0;
    Tx_Data    = 8'h00;
  endtask

  // One cycle: wait for the falling edge, present buffer data one cycle after a strobe.
  task automatic step();
    @(negedge Clk);
    if (rd_pending) begin
      Tx_Data    = (rd_idx < payload.size()) ? payload[rd_idx] : 8'h00;
      rd_idx++;
      rd_pending = 1'b0;
    end
    if (Tx_RdBuff === 1'b1) rd_pending = 1'b1;
  endtask

  task automatic begin_frame(input logic [7:0] size, input logic with_abort);
    step();
    Tx_Enable     = 1'b1;
    Tx_FrameSize  = size;
    Tx_AbortFrame = with_abort;
  endtask

  // Index 0 is the cycle carrying the first flag bit; capture ends at the first idle cycle.
  task automatic run_frame(input int max_cyc, input int abort_at, input int rst_at,
                           input bit hold_en);
    tx_log.delete();
    rd_cnt = 0; done_cnt = 0; ab_cnt = 0; done_at = -1; ab_at = -1;
    idle_tx   = 1'bx;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (Tx_Done === 1'b1) begin done_cnt++; done_at = i; end
      if (Tx_AbortedTrans === 1'b1) begin ab_cnt++; ab_at = i; end
      if (Tx_RdBuff === 1'b1) rd_cnt++;
      if (Tx_Busy !== 1'b1) begin
        idle_tx       = Tx;
        timed_out     = 1'b0;
        Tx_Enable     = 1'b0;
        Tx_AbortFrame = 1'b0;
        Rst           = 1'b0;
        break;
      end
      tx_log.push_back(Tx);
      Tx_Enable     = hold_en;
      Tx_AbortFrame = (i == abort_at);
      Rst           = (i == rst_at);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Tx_Enable = 1'b0; Tx_FrameSize = 8'd0; Tx_AbortFrame = 1'b0; Tx_Data = 8'h00;
    rd_pending = 1'b0;
    step(); step();
    n_checks++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", Tx); end
    n_checks++; if (Tx_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Tx_Busy); end
    n_checks++; if (Tx_RdBuff !== 1'b0) begin n_fail++; $display("FAIL reset_rdbuff: got %b expected 0", Tx_RdBuff); end
    n_checks++; if (Tx_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Tx_Done); end
    n_checks++; if (Tx_AbortedTrans !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b expected 0", Tx_AbortedTrans); end
    Rst = 1'b0;
    step();
  endtask

  task automatic test_single_ff();
    string exp = "0111111011111011101111110";
    string act;
    load_payload(8'hFF, 8'h00, 8'h00, 8'h00, 1);
    begin_frame(8'd1, 1'b0);
    run_frame(100, -1, -1, 1'b0);
    act = log_str();
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ff_timeout: got busy after 100 cycles expected idle"); end
    n_checks++; if (act != exp) begin n_fail++; $display("FAIL ff_bits: got %s expected %s", act, exp); end
    n_checks++; if (rd_cnt != 1) begin n_fail++; $display("FAIL ff_rdbuff: got %0d expected 1", rd_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ff_done_cnt: got %0d expected 1", done_cnt); end
    n_checks++; if (done_at != 25) begin n_fail++; $display("FAIL ff_done_at: got %0d expected 25", done_at); end
    n_checks++; if (idle_tx !== 1'b1) begin n_fail++; $display("FAIL ff_idle_tx: got %b expected 1", idle_tx); end
  endtask

  // Tx_Enable is held high throughout to show it is ignored while busy.
  task automatic test_no_stuff();
    string exp = {"01111110", "00000000", "10100101", "00111100", "01111110"};
    string act;
    load_payload(8'h00, 8'hA5, 8'h3C, 8'h00, 3);
    begin_frame(8'd3, 1'b0);
    run_frame(200, -1, -1, 1'b1);
    act = log_str();
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ns_timeout: got busy after 200 cycles expected idle"); end
    n_checks++; if (tx_log.size() != 40) begin n_fail++; $display("FAIL ns_len: got %0d expected 40", tx_log.size()); end
    n_checks++; if (act != exp) begin n_fail++; $display("FAIL ns_bits: got %s expected %s", act, exp); end
    n_checks++; if (rd_cnt != 3) begin n_fail++; $display("FAIL ns_rdbuff: got %0d expected 3", rd_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ns_done_cnt: got %0d expected 1", done_cnt); end
    step();
    n_checks++; if (Tx_Busy !== 1'b0) begin n_fail++; $display("FAIL ns_no_restart: got busy %b expected 0", Tx_Busy); end
  endtask

  // Abort asserted together with the start request must be ignored.
  task automatic test_flag_payload();
    string exp = {"01111110", "011111010", "01111110"};
    string act;
    int    n;
    load_payload(8'h7E, 8'h00, 8'h00, 8'h00, 1);
    begin_frame(8'd1, 1'b1);
    run_frame(100, -1, -1, 1'b0);
    act = log_str();
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL fp_timeout: got busy after 100 cycles expected idle"); end
    n_checks++; if (act != exp) begin n_fail++; $display("FAIL fp_bits: got %s expected %s", act, exp); end
    n = (act.len() >= 17) ? count_flags(act, 1, act.len() - 9) : -1;
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL fp_inner_flag: got %0d expected 0", n); end
    n_checks++; if (ab_cnt != 0) begin n_fail++; $display("FAIL fp_abort: got %0d expected 0", ab_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL fp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  // Abort sampled while byte 2 bit 2 is on the line (cycle 18).
  task automatic test_abort();
    string exp = {"01111110", "00000000", "000", "01111111"};
    string act;
    load_payload(8'h00, 8'h00, 8'h00, 8'h00, 4);
    begin_frame(8'd4, 1'b0);
    run_frame(100, 18, -1, 1'b0);
    act = log_str();
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ab_timeout: got busy after 100 cycles expected idle"); end
    n_checks++; if (act != exp) begin n_fail++; $display("FAIL ab_bits: got %s expected %s", act, exp); end
    n_checks++; if (ab_cnt != 1) begin n_fail++; $display("FAIL ab_cnt: got %0d expected 1", ab_cnt); end
    n_checks++; if (ab_at != 27) begin n_fail++; $display("FAIL ab_at: got %0d expected 27", ab_at); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL ab_done: got %0d expected 0", done_cnt); end
    n_checks++; if (rd_cnt != 2) begin n_fail++; $display("FAIL ab_rdbuff: got %0d expected 2", rd_cnt); end
    n_checks++; if (idle_tx !== 1'b1) begin n_fail++; $display("FAIL ab_idle_tx: got %b expected 1", idle_tx); end
    step();
    n_checks++; if (Tx !== 1'b1 || Tx_Busy !== 1'b0) begin n_fail++; $display("FAIL ab_after: got tx=%b busy=%b expected tx=1 busy=0", Tx, Tx_Busy); end
  endtask

  task automatic test_illegal_size();
    logic [7:0] sizes[2];
    sizes[0] = 8'd0;
    sizes[1] = 8'd129;
    foreach (sizes[k]) begin
      step();
      Tx_Enable    = 1'b1;
      Tx_FrameSize = sizes[k];
      for (int c = 0; c < 4; c++) begin
        step();
        Tx_Enable = 1'b0;
        n_checks++;
        if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Tx_RdBuff !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_size_%0d: got tx=%b busy=%b rd=%b expected tx=1 busy=0 rd=0",
                   sizes[k], Tx, Tx_Busy, Tx_RdBuff);
        end
      end
    end
  endtask

  task automatic test_max_size();
    load_payload(8'h00, 8'h00, 8'h00, 8'h00, 0);
    begin_frame(8'd128, 1'b0);
    run_frame(2000, -1, -1, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL max_timeout: got busy after 2000 cycles expected idle"); end
    n_checks++; if (tx_log.size() != 1040) begin n_fail++; $display("FAIL max_len: got %0d expected 1040", tx_log.size()); end
    n_checks++; if (rd_cnt != 128) begin n_fail++; $display("FAIL max_rdbuff: got %0d expected 128", rd_cnt); end
    n_checks++; if (done_at != 1040) begin n_fail++; $display("FAIL max_done_at: got %0d expected 1040", done_at); end
  endtask

  task automatic test_reset_mid_frame();
    string exp = "0111111011111011101111110";
    string act;
    load_payload(8'h55, 8'h55, 8'h00, 8'h00, 2);
    begin_frame(8'd2, 1'b0);
    run_frame(100, -1, 12, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rst_timeout: got busy after 100 cycles expected idle"); end
    n_checks++; if (tx_log.size() != 13) begin n_fail++; $display("FAIL rst_len: got %0d expected 13", tx_log.size()); end
    n_checks++; if (idle_tx !== 1'b1) begin n_fail++; $display("FAIL rst_idle_tx: got %b expected 1", idle_tx); end
    n_checks++; if (done_cnt != 0 || ab_cnt != 0) begin n_fail++; $display("FAIL rst_pulses: got done=%0d abort=%0d expected 0 0", done_cnt, ab_cnt); end
    step();
    n_checks++; if (Tx_Done !== 1'b0 || Tx_AbortedTrans !== 1'b0 || Tx !== 1'b1) begin n_fail++; $display("FAIL rst_quiet: got done=%b abort=%b tx=%b expected 0 0 1", Tx_Done, Tx_AbortedTrans, Tx); end
    load_payload(8'hFF, 8'h00, 8'h00, 8'h00, 1);
    begin_frame(8'd1, 1'b0);
    run_frame(100, -1, -1, 1'b0);
    act = log_str();
    n_checks++; if (act != exp) begin n_fail++; $display("FAIL rst_refr_bits: got %s expected %s", act, exp); end
    n_checks++; if (done_at != 25 || rd_cnt != 1) begin n_fail++; $display("FAIL rst_refr_done: got done_at=%0d rd=%0d expected 25 1", done_at, rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_ff();
    test_no_stuff();
    test_flag_payload();
    test_abort();
    test_illegal_size();
    test_max_size();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
